bkg_line_fetcher: RTL and testbench
===================================

Name: bkg_line_fetcher

Overview:
- Parametrised background renderer. Replaces per-pixel SRAM lookups with a per-scanline prefetch into a ping-pong line buffer.
- Above a configurable horizon row it outputs a constant sky colour. At and below the horizon it outputs a tiled SRC_W x SRC_H image fetched from SRAM during horizontal blanking.
- Sits between the VGA counter (DrawX/DrawY) and the colour mapper; owns the read side of the background SRAM port.

Parameters:
- PIXEL_W, 16, colour/SRAM data width.
- ADDR_W, 20, SRAM address width.
- SRC_W, 64, tile width in pixels; power of 2, 8..256.
- SRC_H, 8, tile height in rows; power of 2.
- RD_LAT, 2, Clk cycles from address issue to valid sram_rdata; 1..4.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, total lines per frame.
- GROUND_Y, 360, first tiled row.
- SKY_COLOR, 16'h0000, colour above GROUND_Y.
- FALLBACK_COLOR, 16'hF81F, colour when the line buffer is not ready.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current line.
- base_addr  in  ADDR_W  SRAM word address of tile row 0, column 0; sampled at fetch start.
- SRAM_ADDR  out  ADDR_W  read address.
- SRAM_CE_N  out  1  chip enable, low only while fetching.
- SRAM_OE_N  out  1  output enable, low only while fetching.
- SRAM_WE_N  out  1  constant 1 (read-only port).
- SRAM_UB_N  out  1  equals SRAM_CE_N.
- SRAM_LB_N  out  1  equals SRAM_CE_N.
- sram_rdata  in  PIXEL_W  SRAM read data.
- bkg_color  out  PIXEL_W  registered background colour.
- fetch_busy  out  1  high while the FSM is in FETCH or DRAIN.
- fetch_late  out  1  sticky underrun/overrun flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release) sets:
  - FSM = IDLE.
  - SRAM_CE_N = SRAM_OE_N = SRAM_WE_N = 1; SRAM_ADDR = 0.
  - bkg_color = 0, fetch_busy = 0, fetch_late = 0.
  - Both bank valid bits = 0; both tags = 0.
- Trigger: DrawX is registered each Clk. A fetch request is raised in the single cycle where prev_DrawX == H_ACTIVE-1 and DrawX == H_ACTIVE.
- Target line: ny = DrawY+1, wrapping to 0 when DrawY == V_TOTAL-1. A fetch is issued only if GROUND_Y <= ny < V_ACTIVE. Otherwise no SRAM activity occurs.
- Addressing:
  - Tile row r = (ny - GROUND_Y) mod SRC_H.
  - Word address = base_addr + r*SRC_W + c, c = 0..SRC_W-1.
  - Addition is modulo 2^ADDR_W.
- Write bank is ny[0]; read bank is DrawY[0].
- FSM:
  - IDLE: on a valid trigger, latch ny and base_addr, clear valid[ny[0]], go to FETCH.
  - FETCH: issue one address per cycle, c = 0..SRC_W-1. CE_N/OE_N are low. After c = SRC_W-1 go to DRAIN.
  - DRAIN: a RD_LAT-deep valid/index shift pipe writes sram_rdata into buf[bank][idx] as each entry matures. When the pipe is empty, set valid[bank] = 1 and tag[bank] = ny, then return to IDLE. CE_N/OE_N return to 1 on entry to DRAIN + RD_LAT cycles.
- Fetch length: exactly SRC_W + RD_LAT cycles from leaving IDLE to returning to IDLE.
- Overrun: if a new trigger arrives while not in IDLE:
  - abort the current fetch and discard pending pipe entries;
  - set fetch_late;
  - restart in FETCH for the new line.
- Pixel output, registered with 1-cycle latency from DrawX/DrawY:
  - DrawX >= H_ACTIVE or DrawY >= V_ACTIVE → 0.
  - DrawY < GROUND_Y → SKY_COLOR.
  - valid[DrawY[0]] and tag == DrawY → buf[DrawY[0]][DrawX mod SRC_W].
  - otherwise → FALLBACK_COLOR; also set fetch_late.
- Frame wrap: line 0 is sky, so there is no fetch for it. Stale tags from the previous frame never match because ny is compared in full.

Optional Feature:
- Macro: BKG_HSCROLL_EN.
- With the macro defined:
  - adds input scroll_x [9:0];
  - read column = (DrawX + scroll_x) mod SRC_W;
  - scroll_x is sampled once per line at DrawX == 0 so the line shears cleanly.
- Without the macro: no scroll_x port; read column = DrawX mod SRC_W.

Test Plan:
- Reset asserted mid-FETCH (DrawY=400) → all outputs go to reset values within the same cycle, and the FSM returns to IDLE with no further SRAM_CE_N low.
- DrawY=359, DrawX steps 639→640, base_addr=0x01000, SRC_W=64 → SRAM_ADDR sequence 0x01000..0x0103F on consecutive cycles; fetch_busy high for exactly 66 cycles.
- Memory word = (address low byte). Lines 360..367 rendered → line 362 at DrawX=70 shows 0x86 (row 2, col 6); line 368 repeats row 0.
- DrawY=100, any DrawX<640 → bkg_color = SKY_COLOR one cycle later; no SRAM access on DrawY=99→100.
- Second trigger forced during FETCH → fetch_late=1; the new line is fetched; the old bank reads FALLBACK_COLOR with fetch_late staying 1.
- BKG_HSCROLL_EN defined, scroll_x=5, row 0 loaded → DrawX=0 shows word 5; DrawX=59 shows word 0 (wrap).

Source files
------------

// File: rtl/bkg_line_fetcher.sv
// Background renderer with per-scanline SRAM prefetch into a ping-pong line buffer.
// Rows above GROUND_Y show SKY_COLOR; rows at and below it show a tiled SRC_W x SRC_H
// image that is fetched during horizontal blanking of the preceding line.
// Optional feature: define BKG_HSCROLL_EN to add a per-line horizontal scroll input.
module bkg_line_fetcher #(
  parameter int unsigned         PIXEL_W        = 16,
  parameter int unsigned         ADDR_W         = 20,
  parameter int unsigned         SRC_W          = 64,
  parameter int unsigned         SRC_H          = 8,
  parameter int unsigned         RD_LAT         = 2,
  parameter int unsigned         H_ACTIVE       = 640,
  parameter int unsigned         V_ACTIVE       = 480,
  parameter int unsigned         V_TOTAL        = 525,
  parameter int unsigned         GROUND_Y       = 360,
  parameter logic [PIXEL_W-1:0]  SKY_COLOR      = 16'h0000,
  parameter logic [PIXEL_W-1:0]  FALLBACK_COLOR = 16'hF81F
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
`ifdef BKG_HSCROLL_EN
  input  logic [9:0]         scroll_x,
`endif
  input  logic [ADDR_W-1:0]  base_addr,
  output logic [ADDR_W-1:0]  SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  input  logic [PIXEL_W-1:0] sram_rdata,
  output logic [PIXEL_W-1:0] bkg_color,
  output logic               fetch_busy,
  output logic               fetch_late
);

  localparam int unsigned      COL_W      = $clog2(SRC_W);
  localparam logic [9:0]       X_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0]       LAST_X     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       Y_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]       LAST_Y     = 10'(V_TOTAL - 1);
  localparam logic [9:0]       GROUND     = 10'(GROUND_Y);
  localparam logic [9:0]       ROW_MASK   = 10'(SRC_H - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(SRC_W - 1);
  localparam logic [2:0]       LAST_DRAIN = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [2:0]          drain_q, drain_d;
  logic [9:0]          prev_x_q;
  logic [9:0]          ny_q;
  logic [ADDR_W-1:0]   base_q;
  logic [RD_LAT-1:0]   pipe_v_q;
  logic [COL_W-1:0]    pipe_idx_q [RD_LAT];
  logic [1:0]          valid_q;
  logic [9:0]          tag_q [2];
  logic [PIXEL_W-1:0]  color_q;
  logic                late_q;
  logic [PIXEL_W-1:0]  line_buf [2][SRC_W];

  logic                trig;
  logic [9:0]          ny_next;
  logic                ny_ok;
  logic                start;
  logic                abort;
  logic                fetch_done;
  logic [9:0]          row_idx;
  logic [ADDR_W-1:0]   offset;

  logic                rd_bank;
  logic [COL_W-1:0]    rd_col;
  logic                hit;
  logic                miss;
  logic [PIXEL_W-1:0]  pix_d;

  // Trigger fires on the single cycle where the column crosses into horizontal blanking.
  assign trig    = (prev_x_q == LAST_X) && (DrawX == X_ACT);
  assign ny_next = (DrawY == LAST_Y) ? 10'd0 : DrawY + 10'd1;
  assign ny_ok   = (ny_next >= GROUND) && (ny_next < Y_ACT);
  assign start   = trig && ny_ok;
  // Any trigger while busy is an overrun: the running fetch is abandoned.
  assign abort   = trig && (state_q != StIdle);
  assign fetch_done = (state_q == StDrain) && (drain_q == LAST_DRAIN) && !trig;

  assign row_idx = (ny_q - GROUND) & ROW_MASK;
  assign offset  = ADDR_W'(row_idx) * ADDR_W'(SRC_W) + ADDR_W'(col_q);

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and counter update
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          col_d   = '0;
        end
      end
      StFetch: begin
        col_d = col_q + COL_W'(1);
        if (col_q == LAST_COL) begin
          state_d = StDrain;
          drain_d = 3'd0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == LAST_DRAIN) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Overrun restarts for the new line, or goes idle if that line needs no fetch.
    if (abort) begin
      state_d = ny_ok ? StFetch : StIdle;
      col_d   = '0;
      drain_d = 3'd0;
    end
  end

  // FSM outputs: SRAM control is asserted for the whole FETCH + DRAIN window
  always_comb begin
    fetch_busy = (state_q != StIdle);
    SRAM_CE_N  = !fetch_busy;
    SRAM_OE_N  = !fetch_busy;
    SRAM_WE_N  = 1'b1;
    SRAM_UB_N  = SRAM_CE_N;
    SRAM_LB_N  = SRAM_CE_N;
    SRAM_ADDR  = '0;
    if (state_q == StFetch) begin
      SRAM_ADDR = base_q + offset;
    end
  end

  // Fetch datapath: counters, latched request, read-return pipe, bank bookkeeping, pixel reg
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_x_q   <= '0;
      col_q      <= '0;
      drain_q    <= '0;
      ny_q       <= '0;
      base_q     <= '0;
      pipe_v_q   <= '0;
      pipe_idx_q <= '{default: '0};
      valid_q    <= '0;
      tag_q      <= '{default: '0};
      color_q    <= '0;
      late_q     <= 1'b0;
    end else begin
      prev_x_q <= DrawX;
      col_q    <= col_d;
      drain_q  <= drain_d;
      if (start) begin
        ny_q   <= ny_next;
        base_q <= base_addr;
      end
      pipe_v_q[0]   <= (state_q == StFetch) && !abort;
      pipe_idx_q[0] <= col_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1] && !abort;
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
      if (start) begin
        valid_q[ny_next[0]] <= 1'b0;
      end
      if (fetch_done) begin
        valid_q[ny_q[0]] <= 1'b1;
        tag_q[ny_q[0]]   <= ny_q;
      end
      color_q <= pix_d;
      late_q  <= late_q | abort | miss;
    end
  end

  // Line buffer write as each read matures; aborted entries are dropped
  always_ff @(posedge Clk) begin
    if (pipe_v_q[RD_LAT-1] && !abort) begin
      line_buf[ny_q[0]][pipe_idx_q[RD_LAT-1]] <= sram_rdata;
    end
  end

`ifdef BKG_HSCROLL_EN
  logic [9:0] scroll_q;
  logic [9:0] scroll_eff;

  // Scroll is captured at the start of each line so the whole line uses one offset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scroll_q <= '0;
    end else if (DrawX == 10'd0) begin
      scroll_q <= scroll_x;
    end
  end

  assign scroll_eff = (DrawX == 10'd0) ? scroll_x : scroll_q;
  // 10-bit wrap is harmless since 1024 is a multiple of SRC_W.
  assign rd_col     = COL_W'((DrawX + scroll_eff) % 10'(SRC_W));
`else
  assign rd_col     = DrawX[COL_W-1:0];
`endif

  assign rd_bank = DrawY[0];
  assign hit     = valid_q[rd_bank] && (tag_q[rd_bank] == DrawY);

  // Pixel selection: blanking, sky, buffered tile, or fallback on a missing line
  always_comb begin
    pix_d = '0;
    miss  = 1'b0;
    if ((DrawX >= X_ACT) || (DrawY >= Y_ACT)) begin
      pix_d = '0;
    end else if (DrawY < GROUND) begin
      pix_d = SKY_COLOR;
    end else if (hit) begin
      pix_d = line_buf[rd_bank][rd_col];
    end else begin
      pix_d = FALLBACK_COLOR;
      miss  = 1'b1;
    end
  end

  assign bkg_color  = color_q;
  assign fetch_late = late_q;

endmodule

// File: tb/tb_bkg_line_fetcher.sv
// Self-checking bench for bkg_line_fetcher: directed table, hand sequences for reset,
// overrun and scroll, and randomized fetch/read traffic against a line-level model.
module tb_bkg_line_fetcher;

  localparam int SRC_W  = 64;
  localparam int SRC_H  = 8;
  localparam int RD_LAT = 2;
  localparam int HACT   = 640;
  localparam int VACT   = 480;
  localparam int VTOT   = 525;
  localparam int GROUND = 360;
  localparam logic [15:0] SKY      = 16'h0000;
  localparam logic [15:0] FALLBACK = 16'hF81F;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [19:0] base_addr = '0;
`ifdef BKG_HSCROLL_EN
  logic [9:0]  scroll_x = '0;
`endif
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [15:0] sram_rdata;
  logic [15:0] bkg_color;
  logic        fetch_busy, fetch_late;

  bkg_line_fetcher #(
    .PIXEL_W(16), .ADDR_W(20), .SRC_W(SRC_W), .SRC_H(SRC_H), .RD_LAT(RD_LAT),
    .H_ACTIVE(HACT), .V_ACTIVE(VACT), .V_TOTAL(VTOT), .GROUND_Y(GROUND),
    .SKY_COLOR(SKY), .FALLBACK_COLOR(FALLBACK)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
`ifdef BKG_HSCROLL_EN
    .scroll_x(scroll_x),
`endif
    .base_addr(base_addr), .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .sram_rdata(sram_rdata), .bkg_color(bkg_color),
    .fetch_busy(fetch_busy), .fetch_late(fetch_late)
  );

  always #5 Clk = ~Clk;

  // SRAM model: word = low byte of address, returned RD_LAT cycles after issue
  logic [19:0] addr_hist [RD_LAT];
  always @(posedge Clk) begin
    addr_hist[0] <= SRAM_ADDR;
    for (int i = 1; i < RD_LAT; i++) addr_hist[i] <= addr_hist[i-1];
  end
  assign sram_rdata = {8'h00, addr_hist[RD_LAT-1][7:0]};

  // Bus monitor
  int          ce_cnt = 0;
  logic [19:0] addr_log [$];
  always @(posedge Clk) begin
    if (!SRAM_CE_N) ce_cnt++;
    if (fetch_busy) addr_log.push_back(SRAM_ADDR);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Line-level reference model
  bit m_valid [2];
  int m_tag   [2];
  int m_base  [2];
  bit m_late;

  task automatic model_reset;
    m_valid = '{0, 0};
    m_tag   = '{0, 0};
    m_base  = '{0, 0};
    m_late  = 0;
  endtask

  function automatic int m_addr(int base, int ny, int c);
    return (base + ((ny - GROUND) % SRC_H) * SRC_W + c) % (1 << 20);
  endfunction

  function automatic int m_pix(int x, int y);
    int b;
    if (x >= HACT || y >= VACT) return 0;
    if (y < GROUND) return int'(SKY);
    b = y % 2;
    if (m_valid[b] && m_tag[b] == y) return m_addr(m_base[b], y, x % SRC_W) & 255;
    return int'(FALLBACK);
  endfunction

  task automatic set_xy(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  task automatic pulse_reset;
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    model_reset();
  endtask

  // Raise a trigger with DrawY=trig_y, let the fetch run out, and check the bus traffic.
  task automatic trigger_line(input int trig_y, input int base);
    int ny;
    bit ok;
    int idx;
    ny = (trig_y == VTOT - 1) ? 0 : trig_y + 1;
    ok = (ny >= GROUND) && (ny < VACT);
    base_addr = 20'(base);
    set_xy(639, 0);
    tick();
    addr_log.delete();
    ce_cnt = 0;
    set_xy(640, trig_y);
    tick();
    repeat (SRC_W + RD_LAT + 6) tick();
    if (ok) begin
      check("fetch busy length", addr_log.size(), SRC_W + RD_LAT);
      check("fetch ce length", ce_cnt, SRC_W + RD_LAT);
      idx = 0;
      for (int i = 0; i < SRC_W && i < addr_log.size(); i++) begin
        if (int'(addr_log[i]) != m_addr(base, ny, i)) begin
          idx = i;
          break;
        end
      end
      if (addr_log.size() > idx) check("fetch addr seq", addr_log[idx], m_addr(base, ny, idx));
      check("fetch ends idle", fetch_busy, 0);
      m_valid[ny % 2] = 1;
      m_tag[ny % 2]   = ny;
      m_base[ny % 2]  = base;
    end else begin
      check("no fetch outside ground band", ce_cnt, 0);
    end
  endtask

  // Drive one pixel, then compare color and sticky flag with the model.
  task automatic read_check(input int x, input int y);
    int exp;
    if (DrawX == 10'd639 && x == 640) x = 641;
    set_xy(x, y);
    tick();
    exp = m_pix(x, y);
    // Tile words are 8-bit, so FALLBACK can only mean a missing line.
    if (exp == int'(FALLBACK)) m_late = 1;
    check("random pixel", bkg_color, exp);
    check("random late", fetch_late, m_late);
  endtask

  typedef struct {
    int fetch_y;   // DrawY for a trigger before the read, -1 for none
    int base;
    int x;
    int y;
    int exp_color;
    int exp_late;
  } vec_t;

  vec_t vt [14];

  initial begin
    vt = '{
      '{361, 32'h01000,  70, 362, 32'h0086, 0},  // row 2 col 6
      '{362, 32'h01000,   5, 363, 32'h00C5, 0},  // row 3 col 5
      '{ -1, 0,           0, 362, 32'h0080, 0},
      '{ -1, 0,          63, 362, 32'h00BF, 0},
      '{ -1, 0,          64, 362, 32'h0080, 0},  // tile wraps horizontally
      '{ -1, 0,         639, 363, 32'h00FF, 0},
      '{ -1, 0,         700, 363, 32'h0000, 0},  // horizontal blanking
      '{ -1, 0,          10, 100, 32'h0000, 0},  // sky
      '{ -1, 0,          10, 359, 32'h0000, 0},  // last sky line
      '{ -1, 0,          10, 480, 32'h0000, 0},  // vertical blanking
      '{367, 32'h01000,   6, 368, 32'h0006, 0},  // row 0 repeats
      '{ -1, 0,           6, 363, 32'h00C6, 0},
      '{ -1, 0,           6, 362, 32'hF81F, 1},  // bank now holds 368
      '{ -1, 0,           6, 363, 32'h00C6, 1}   // flag is sticky
    };

    // Reset state
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("reset ce_n", SRAM_CE_N, 1);
    check("reset oe_n", SRAM_OE_N, 1);
    check("reset we_n", SRAM_WE_N, 1);
    check("reset addr", SRAM_ADDR, 0);
    check("reset color", bkg_color, 0);
    check("reset busy", fetch_busy, 0);
    check("reset late", fetch_late, 0);
    Reset_n = 1'b1;
    tick();

    // Sky line: no fetch for line 100, sky colour shown
    set_xy(639, 0);
    tick();
    ce_cnt = 0;
    set_xy(640, 99);
    tick();
    repeat (80) tick();
    check("sky no sram", ce_cnt, 0);
    set_xy(5, 100);
    tick();
    check("sky color", bkg_color, SKY);
    check("sky late", fetch_late, 0);

    // First ground line address sequence
    trigger_line(359, 32'h01000);
    if (addr_log.size() >= SRC_W) begin
      check("line360 first addr", addr_log[0], 20'h01000);
      check("line360 last addr", addr_log[SRC_W-1], 20'h0103F);
    end else begin
      check("line360 addr count", addr_log.size(), SRC_W);
    end

    // Table-driven pixel checks
    for (int i = 0; i < 14; i++) begin
      if (vt[i].fetch_y >= 0) trigger_line(vt[i].fetch_y, vt[i].base);
      set_xy(vt[i].x, vt[i].y);
      tick();
      check($sformatf("vec%0d color", i), bkg_color, vt[i].exp_color);
      check($sformatf("vec%0d late", i), fetch_late, vt[i].exp_late);
    end

    // Reset asserted mid-fetch
    set_xy(639, 0);
    tick();
    set_xy(640, 400);
    tick();
    repeat (10) tick();
    check("midfetch busy", fetch_busy, 1);
    check("midfetch ce_n", SRAM_CE_N, 0);
    check("midfetch ub_n", SRAM_UB_N, 0);
    check("midfetch lb_n", SRAM_LB_N, 0);
    Reset_n = 1'b0;
    #1;
    check("async ce_n", SRAM_CE_N, 1);
    check("async oe_n", SRAM_OE_N, 1);
    check("async addr", SRAM_ADDR, 0);
    check("async busy", fetch_busy, 0);
    check("async late", fetch_late, 0);
    check("async color", bkg_color, 0);
    #1;
    Reset_n = 1'b1;
    model_reset();
    ce_cnt = 0;
    repeat (100) tick();
    check("post reset no sram", ce_cnt, 0);

    // Randomized fetches and reads against the model
    for (int it = 0; it < 30; it++) begin
      int ty;
      int ny;
      ty = ($urandom_range(0, 9) == 0) ? VTOT - 1 : int'($urandom_range(350, 485));
      ny = (ty == VTOT - 1) ? 0 : ty + 1;
      trigger_line(ty, int'($urandom_range(0, 32'hFFFFF)));
      for (int k = 0; k < 2; k++) read_check(int'($urandom_range(0, 799)), ny);
      for (int k = 0; k < 6; k++)
        read_check(int'($urandom_range(0, 799)), int'($urandom_range(355, 485)));
    end

    // Overrun: second trigger during FETCH
    pulse_reset();
    tick();
    base_addr = 20'h02000;
    set_xy(639, 0);
    tick();
    set_xy(640, 359);
    tick();
    repeat (10) tick();
    check("overrun pre late", fetch_late, 0);
    check("overrun pre busy", fetch_busy, 1);
    set_xy(639, 0);
    tick();
    set_xy(640, 360);
    tick();
    check("overrun late", fetch_late, 1);
    repeat (80) tick();
    check("overrun idle", fetch_busy, 0);
    set_xy(3, 361);
    tick();
    check("overrun new line", bkg_color, 16'h0043);
    set_xy(3, 360);
    tick();
    check("overrun old bank", bkg_color, FALLBACK);
    check("overrun late sticky", fetch_late, 1);

`ifdef BKG_HSCROLL_EN
    // Horizontal scroll with wrap, sampled at column 0
    trigger_line(359, 0);
    scroll_x = 10'd5;
    set_xy(0, 360);
    tick();
    check("scroll col0", bkg_color, 16'h0005);
    scroll_x = 10'd9;
    set_xy(59, 360);
    tick();
    check("scroll wrap", bkg_color, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
